// File: rtl/alu_pkg.sv
// ALUfn encodings and arbiter FSM state type shared by the ALU and the arbiter.
package alu_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b10001;
  localparam logic [4:0] ALU_SLL = 5'b00010;
  localparam logic [4:0] ALU_SRL = 5'b01010;
  localparam logic [4:0] ALU_SRA = 5'b01110;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00100;
  localparam logic [4:0] ALU_XOR = 5'b01000;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_LT  = 5'b10011;
  localparam logic [4:0] ALU_LTU = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Shifts move operand B by the amount in the low bits of A.
// Comparisons return 0/1 in bit 0. Undefined fn codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       fn,
  output logic [WIDTH-1:0] r,
  output logic             z
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SHW-1:0] shamt;
  assign shamt = a[SHW-1:0];

  // Result select by function code.
  always_comb begin
    r = '0;
    case (fn)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLL: r = b << shamt;
      ALU_SRL: r = b >> shamt;
      ALU_SRA: r = $unsigned($signed(b) >>> shamt);
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOR: r = ~(a | b);
      ALU_LT:  r[0] = ($signed(a) < $signed(b));
      ALU_LTU: r[0] = (a < b);
      default: r = '0;
    endcase
  end

  assign z = (r == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for a request; granted requester sees ready
//  EXEC    | ALU evaluates latched operands; result registered at exit
//  RESP    | result offered to the granted requester until it takes it
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_fn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_fn,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_z,
  output logic [7:0]       done_count
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;   // preferred requester when both are valid
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [4:0]       fn_q, fn_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_r_q, rsp_r_d;
  logic             rsp_z_q, rsp_z_d;
  logic [7:0]       done_count_q, done_count_d;

  logic             any_valid;
  logic             grant_id;
  logic             rsp_take;
  logic [WIDTH-1:0] alu_r;
  logic             alu_z;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .fn (fn_q),
    .r  (alu_r),
    .z  (alu_z)
  );

  // Round-robin grant: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) grant_id = ptr_q;
    else if (req1_valid)          grant_id = 1'b1;
    rsp_take  = id_q ? rsp1_ready : rsp0_ready;
  end

  // Next-state, datapath capture and handshake outputs.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    fn_d         = fn_q;
    id_d         = id_q;
    rsp_r_d      = rsp_r_q;
    rsp_z_d      = rsp_z_q;
    done_count_d = done_count_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!reset && any_valid) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          a_d        = grant_id ? req1_a  : req0_a;
          b_d        = grant_id ? req1_b  : req0_b;
          fn_d       = grant_id ? req1_fn : req0_fn;
          id_d       = grant_id;
          ptr_d      = ~grant_id;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_r_d = alu_r;
        rsp_z_d = alu_z;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!reset) begin
          rsp0_valid = ~id_q;
          rsp1_valid = id_q;
        end
        if (rsp_take) begin
          done_count_d = done_count_q + 8'd1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      fn_q         <= '0;
      id_q         <= 1'b0;
      rsp_r_q      <= '0;
      rsp_z_q      <= 1'b0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      fn_q         <= fn_d;
      id_q         <= id_d;
      rsp_r_q      <= rsp_r_d;
      rsp_z_q      <= rsp_z_d;
      done_count_q <= done_count_d;
    end
  end

  assign rsp_r      = rsp_r_q;
  assign rsp_z      = rsp_z_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized operations
// checked against a transaction-level model of arbitration and ALU results.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0] req0_fn, req1_fn;
  logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [7:0] rsp_r;
  logic       rsp_z;
  logic [7:0] done_count;

  int checks = 0;
  int errors = 0;
  int pref = 0;        // requester that wins a tie
  int exp_count = 0;

  localparam logic [4:0] F_ADD = 5'b00001, F_SUB = 5'b10001, F_SLL = 5'b00010,
                         F_SRL = 5'b01010, F_SRA = 5'b01110, F_AND = 5'b00000,
                         F_OR = 5'b00100, F_XOR = 5'b01000, F_NOR = 5'b01100,
                         F_LT = 5'b10011, F_LTU = 5'b10111;

  logic [4:0] fn_tab [12] = '{F_ADD, F_SUB, F_SLL, F_SRL, F_SRA, F_AND,
                              F_OR, F_XOR, F_NOR, F_LT, F_LTU, 5'b11111};

  alu_arbiter #(.WIDTH(8)) dut (
    .clock(clk), .reset(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_fn(req0_fn),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_fn(req1_fn),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_r(rsp_r), .rsp_z(rsp_z), .done_count(done_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] alu_model(input int a, input int b, input logic [4:0] fn);
    int sa, sb, sh, res;
    sh = a % 8;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (fn)
      F_ADD: res = a + b;
      F_SUB: res = a - b;
      F_SLL: res = b << sh;
      F_SRL: res = b >> sh;
      F_SRA: res = sb >>> sh;
      F_AND: res = a & b;
      F_OR:  res = a | b;
      F_XOR: res = a ^ b;
      F_NOR: res = ~(a | b);
      F_LT:  res = (sa < sb) ? 1 : 0;
      F_LTU: res = (a < b) ? 1 : 0;
      default: res = 0;
    endcase
    res = res & 255;
    return res[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at negedge+1. Presents requests, follows one operation to completion.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [7:0] a0, input logic [7:0] b0, input logic [4:0] f0,
                        input logic [7:0] a1, input logic [7:0] b1, input logic [4:0] f1,
                        input int hold, input bit poke_other);
    int g;
    logic [7:0] er;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_fn = f0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_fn = f1;
    #1;
    g = (v0 && v1) ? pref : (v0 ? 0 : 1);
    check("idle_rsp0_valid", rsp0_valid, 0);
    check("idle_rsp1_valid", rsp1_valid, 0);
    check("grant_req0_ready", req0_ready, (g == 0));
    check("grant_req1_ready", req1_ready, (g == 1));
    er = (g == 0) ? alu_model(a0, b0, f0) : alu_model(a1, b1, f1);
    @(posedge clk);
    pref = 1 - g;
    @(negedge clk);
    if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
    check("exec_req0_ready", req0_ready, 0);
    check("exec_req1_ready", req1_ready, 0);
    check("exec_rsp0_valid", rsp0_valid, 0);
    check("exec_rsp1_valid", rsp1_valid, 0);
    @(negedge clk);
    #1;
    for (int i = 0; i <= hold; i++) begin
      check("resp_rsp0_valid", rsp0_valid, (g == 0));
      check("resp_rsp1_valid", rsp1_valid, (g == 1));
      check("resp_rsp_r", rsp_r, er);
      check("resp_rsp_z", rsp_z, (er == 8'd0));
      check("resp_req0_ready", req0_ready, 0);
      check("resp_req1_ready", req1_ready, 0);
      if (i == hold) begin
        rsp0_ready = (g == 0);
        rsp1_ready = (g == 1);
      end else begin
        rsp0_ready = poke_other && (g == 1);
        rsp1_ready = poke_other && (g == 0);
      end
      @(negedge clk);
      #1;
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    check("done_count", done_count, exp_count);
    check("after_rsp0_valid", rsp0_valid, 0);
    check("after_rsp1_valid", rsp1_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pref = 0;
    exp_count = 0;
    #1;
  endtask

  initial begin
    int v;
    bit rv0, rv1;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_fn = '0;
    req1_a = '0; req1_b = '0; req1_fn = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_done_count", done_count, 0);
    check("rst_rsp_r", rsp_r, 0);
    check("rst_rsp_z", rsp_z, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;

    // req0 alone, ADD 10+20
    run_op(1, 0, 8'd10, 8'd20, F_ADD, 8'd0, 8'd0, F_ADD, 0, 0);
    check("add_result", rsp_r, 30);
    check("add_count", done_count, 1);
    // req1 alone, SUB 1-1 sets zero flag
    run_op(0, 1, 8'd0, 8'd0, F_ADD, 8'd1, 8'd1, F_SUB, 0, 0);
    check("sub_zero", rsp_z, 1);

    // both valid after reset: req0 first, then req1
    do_reset();
    run_op(1, 1, 8'd2, 8'd20, F_SLL, 8'd1, 8'hFE, F_SRA, 0, 0);
    check("sll_result", rsp_r, 80);
    run_op(0, 1, 8'd2, 8'd20, F_SLL, 8'd1, 8'hFE, F_SRA, 0, 0);
    check("both_count", done_count, 2);

    // sustained contention alternates grants; slow and foreign rsp_ready
    run_op(1, 1, 8'd7, 8'd9, F_XOR, 8'd3, 8'd4, F_OR, 5, 0);
    run_op(1, 1, 8'd7, 8'd9, F_XOR, 8'd3, 8'd4, F_OR, 3, 1);
    run_op(1, 1, 8'h80, 8'd1, F_LT, 8'h0F, 8'hF0, F_NOR, 0, 1);
    run_op(1, 1, 8'h80, 8'd1, F_LTU, 8'h0F, 8'hF0, F_AND, 2, 0);

    // reset during EXEC aborts the operation
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd236; req0_fn = F_LTU;
    req1_valid = 1'b0;
    #1;
    check("abort_grant", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_rsp0_valid_exec", rsp0_valid, 0);
    @(negedge clk);
    #1;
    check("abort_rsp0_valid", rsp0_valid, 0);
    check("abort_rsp1_valid", rsp1_valid, 0);
    check("abort_done_count", done_count, 0);
    check("abort_rsp_r", rsp_r, 0);
    rst = 1'b0;
    pref = 0;
    exp_count = 0;
    @(negedge clk);
    #1;
    check("abort_idle_rsp0", rsp0_valid, 0);
    run_op(1, 1, 8'd5, 8'd6, F_ADD, 8'd1, 8'd2, F_SUB, 0, 0);

    // 256 randomized completions wrap the counter
    do_reset();
    for (int n = 0; n < 256; n++) begin
      v = $urandom_range(1, 3);
      rv0 = v[0];
      rv1 = v[1];
      run_op(rv0, rv1,
             8'($urandom), 8'($urandom), fn_tab[$urandom_range(0, 11)],
             8'($urandom), 8'($urandom), fn_tab[$urandom_range(0, 11)],
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    check("wrap_count", done_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
